// File: rtl/weight_loader.sv
// Weight RAM writer: streams NUM_WORDS weights into consecutive addresses,
// then compares a trailing word against the running modular checksum.
module weight_loader #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 7,
    parameter int NUM_WORDS = 65,
    parameter int BASE_ADDR = 0
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    if (BASE_ADDR + NUM_WORDS > (1 << ADDR_W)) begin : g_range
        $error("weight_loader: BASE_ADDR+NUM_WORDS exceeds RAM");
    end

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] csum;
    logic              xfer;
    logic              launch;

    assign xfer   = in_valid & in_ready;
    assign launch = start & ~busy;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (xfer && word_count == LAST) state_n = CHECK;
            end
            CHECK: begin
                if (xfer) state_n = (in_data == csum) ? DONE : ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    // Flags and handshake decode straight off the state register,
    // so none of them depend on in_valid.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            LOAD, CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            csum       <= '0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (launch) begin
                csum       <= '0;
                word_count <= '0;
            end else if (state == LOAD && xfer) begin
                wr_en      <= 1'b1;
                wr_addr    <= BASE + word_count;
                wr_data    <= in_data;
                csum       <= csum + in_data;
                word_count <= word_count + ONE;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: default instance plus a
// BASE_ADDR=50 / NUM_WORDS=15 instance.
module tb_weight_loader;

    logic       Clock = 1'b0;
    logic       Rst;
    logic       start;
    logic       start2;
    logic       in_valid;
    logic [9:0] in_data;

    logic       in_ready, wr_en, busy, done, err;
    logic [6:0] wr_addr, word_count;
    logic [9:0] wr_data;

    logic       in_ready2, wr_en2, busy2, done2, err2;
    logic [6:0] wr_addr2, word_count2;
    logic [9:0] wr_data2;

    int vecs = 0;
    int miss = 0;

    logic       use2;
    logic       rdy;
    logic [9:0] exp_d [0:64];

    logic [6:0] la  [0:511];
    logic [9:0] ld  [0:511];
    int         wn = 0;
    logic [6:0] la2 [0:31];
    logic [9:0] ld2 [0:31];
    int         wn2 = 0;

    always #5 Clock = ~Clock;

    assign rdy = use2 ? in_ready2 : in_ready;

    weight_loader dut (
        .Clock(Clock), .Rst(Rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    weight_loader #(.BASE_ADDR(50), .NUM_WORDS(15)) dut2 (
        .Clock(Clock), .Rst(Rst), .start(start2),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2), .err(err2), .word_count(word_count2)
    );

    always @(posedge Clock) begin
        if (wr_en) begin
            la[wn[8:0]] <= wr_addr;
            ld[wn[8:0]] <= wr_data;
            wn <= wn + 1;
        end
    end

    always @(posedge Clock) begin
        if (wr_en2) begin
            la2[wn2[4:0]] <= wr_addr2;
            ld2[wn2[4:0]] <= wr_data2;
            wn2 <= wn2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic push(input logic [9:0] d);
        int k = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!rdy && k < 20) begin
            @(negedge Clock);
            k++;
        end
        if (k >= 20) chk("ready timeout", 32'(k), 0);
        @(negedge Clock);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int wb,
                                input int a0, input int n);
        int bad = 0;
        int cnt;
        cnt = use2 ? (wn2 - wb) : (wn - wb);
        chk({tag, " write count"}, 32'(cnt), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [6:0] a;
            logic [9:0] d;
            a = use2 ? la2[wb + i] : la[wb + i];
            d = use2 ? ld2[wb + i] : ld[wb + i];
            if (a !== 7'(a0 + i) || d !== exp_d[i]) bad++;
        end
        chk({tag, " addr/data errors"}, 32'(bad), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         wb;
        logic [9:0] sum;
        logic [28:0] outs;

        Rst = 1'b1; start = 1'b0; start2 = 1'b0;
        in_valid = 1'b0; in_data = '0; use2 = 1'b0;
        idle(2);
        outs = {in_ready, wr_en, wr_addr, wr_data,
                busy, done, err, word_count};
        chk("reset outputs", 32'(outs), 0);
        Rst = 1'b0;
        idle(1);
        chk("idle word_count", 32'(word_count), 0);

        // reset in the middle of a stream
        pulse_start();
        chk("t1 busy after start", 32'(busy), 1);
        for (int i = 0; i < 10; i++) push(10'(i + 5));
        chk("t1 word_count", 32'(word_count), 10);
        chk("t1 wr_en after xfer", 32'(wr_en), 1);
        Rst = 1'b1;
        #1;
        outs = {in_ready, wr_en, wr_addr, wr_data,
                busy, done, err, word_count};
        chk("t1 async reset outputs", 32'(outs), 0);
        @(negedge Clock);
        Rst = 1'b0;
        wb = wn;
        in_valid = 1'b1;
        in_data  = 10'h55;
        idle(3);
        in_valid = 1'b0;
        chk("t1 idle ignores valid", 32'(wn - wb), 0);
        chk("t1 idle in_ready", 32'(in_ready), 0);

        // full load, good checksum 2080 mod 1024 = 32
        for (int i = 0; i < 65; i++) exp_d[i] = 10'(i);
        wb = wn;
        pulse_start();
        chk("t2 word_count cleared", 32'(word_count), 0);
        for (int i = 0; i < 65; i++) push(10'(i));
        chk("t2 word_count 65", 32'(word_count), 65);
        chk("t2 busy in check", 32'(busy), 1);
        push(10'd32);
        chk("t2 done", 32'(done), 1);
        chk("t2 err", 32'(err), 0);
        chk("t2 busy", 32'(busy), 0);
        idle(3);
        chk("t2 done sticky", 32'(done), 1);
        check_writes("t2", wb, 0, 65);

        // bad checksum 33, restart from DONE
        wb = wn;
        pulse_start();
        chk("t3 done cleared", 32'(done), 0);
        for (int i = 0; i < 65; i++) push(10'(i));
        push(10'd33);
        chk("t3 err", 32'(err), 1);
        chk("t3 done", 32'(done), 0);
        idle(3);
        check_writes("t3", wb, 0, 65);

        // stalls and negative weights, checksum wraps
        sum = '0;
        for (int i = 0; i < 65; i++) begin
            case (i % 4)
                0:       exp_d[i] = 10'h200;
                1:       exp_d[i] = 10'h3FF;
                default: exp_d[i] = 10'(i * 7);
            endcase
            sum = sum + exp_d[i];
        end
        wb = wn;
        pulse_start();
        chk("t4 err cleared", 32'(err), 0);
        for (int i = 0; i < 65; i++) begin
            if (i == 20) begin
                idle(3);
                chk("t4 stall word_count", 32'(word_count), 20);
                chk("t4 stall wr_en", 32'(wr_en), 0);
                chk("t4 stall busy", 32'(busy), 1);
            end else begin
                idle(int'($urandom_range(0, 2)));
            end
            push(exp_d[i]);
        end
        idle(2);
        push(sum);
        chk("t4 done", 32'(done), 1);
        chk("t4 err", 32'(err), 0);
        idle(2);
        check_writes("t4", wb, 0, 65);

        // start while busy is ignored
        for (int i = 0; i < 65; i++) exp_d[i] = 10'(i);
        wb = wn;
        pulse_start();
        for (int i = 0; i < 30; i++) push(10'(i));
        chk("t5 word_count 30", 32'(word_count), 30);
        pulse_start();
        chk("t5 busy after start", 32'(busy), 1);
        chk("t5 word_count held", 32'(word_count), 30);
        push(10'd30);
        chk("t5 word_count 31", 32'(word_count), 31);
        for (int i = 31; i < 65; i++) push(10'(i));
        push(10'd32);
        chk("t5 done", 32'(done), 1);
        idle(2);
        check_writes("t5", wb, 0, 65);
        pulse_start();
        chk("t5 restart done", 32'(done), 0);
        chk("t5 restart busy", 32'(busy), 1);
        chk("t5 restart word_count", 32'(word_count), 0);

        // offset instance: 15 words at 50..64, sum 1605 mod 1024 = 581
        Rst = 1'b1;
        idle(1);
        Rst = 1'b0;
        idle(1);
        use2 = 1'b1;
        for (int i = 0; i < 15; i++) exp_d[i] = 10'(100 + i);
        wb = wn2;
        start2 = 1'b1;
        @(negedge Clock);
        start2 = 1'b0;
        chk("t6 busy", 32'(busy2), 1);
        for (int i = 0; i < 15; i++) push(exp_d[i]);
        chk("t6 word_count", 32'(word_count2), 15);
        push(10'd581);
        chk("t6 done", 32'(done2), 1);
        chk("t6 err", 32'(err2), 0);
        idle(2);
        check_writes("t6", wb, 50, 15);
        chk("t6 main dut idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
